// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared state, forwarding and register-zero constants
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } hc_state_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  // A later stage supplies the operand only if it really writes a non-zero register.
  function automatic logic src_hit(input logic we, input logic [4:0] wr, input logic [4:0] src);
    return we && (wr != REG_ZERO) && (wr == src);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline buffer fields in, sequencing controls out
interface hazard_controller_if #(parameter int CW = 16);

  logic [4:0]    ifid_rs, ifid_rt, idex_rs, idex_rt;
  logic          idex_memread;
  logic          exmem_regwrite, memwb_regwrite;
  logic [4:0]    exmem_writereg, memwb_writereg;
  logic          exmem_branch, exmem_zero, mem_wait;
  logic          pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic          ifid_flush, idex_flush, exmem_flush;
  logic          pc_src, kill_fx;
  logic [1:0]    fwd_a, fwd_b, state;
  logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;

  modport master (
    output ifid_rs, ifid_rt, idex_rs, idex_rt, idex_memread,
           exmem_regwrite, exmem_writereg, memwb_regwrite, memwb_writereg,
           exmem_branch, exmem_zero, mem_wait,
    input  pc_write, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, exmem_flush, pc_src, kill_fx,
           fwd_a, fwd_b, state, stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_memread,
           exmem_regwrite, exmem_writereg, memwb_regwrite, memwb_writereg,
           exmem_branch, exmem_zero, mem_wait,
    output pc_write, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, exmem_flush, pc_src, kill_fx,
           fwd_a, fwd_b, state, stall_cnt, flush_cnt, freeze_cnt
  );

endinterface

// File: rtl/hazard_controller_forward_select.sv
// rtl/hazard_controller_forward_select.sv - ALU operand source select for one EX operand
module forward_select
  import hazard_controller_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_exmem_regwrite,
  input  logic [4:0] i_exmem_writereg,
  input  logic       i_memwb_regwrite,
  input  logic [4:0] i_memwb_writereg,
  output logic [1:0] o_fwd
);

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  always_comb begin
    o_fwd = FWD_REG;
    if (src_hit(i_exmem_regwrite, i_exmem_writereg, i_src))
      o_fwd = FWD_EXMEM;
    else if (src_hit(i_memwb_regwrite, i_memwb_writereg, i_src))
      o_fwd = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - five-stage pipeline sequencing: fill, freeze, flush, stall, forwarding
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int FILL_CYCLES = 4,
  parameter int CW          = 16
)(
  input  logic               clk,
  input  logic               rst,
  hazard_controller_if.slave hz
);

  localparam int FW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;

  hc_state_t     r_state, w_next;
  logic [FW-1:0] r_fill;
  logic [CW-1:0] r_stall_cnt, r_flush_cnt, r_freeze_cnt;
  logic          w_taken, w_load_use, w_inc_stall, w_inc_flush, w_inc_freeze;
  logic [1:0]    w_fwd_a, w_fwd_b;

  forward_select u_fwd_a (
    .i_src(hz.idex_rs), .i_exmem_regwrite(hz.exmem_regwrite), .i_exmem_writereg(hz.exmem_writereg),
    .i_memwb_regwrite(hz.memwb_regwrite), .i_memwb_writereg(hz.memwb_writereg), .o_fwd(w_fwd_a)
  );

  forward_select u_fwd_b (
    .i_src(hz.idex_rt), .i_exmem_regwrite(hz.exmem_regwrite), .i_exmem_writereg(hz.exmem_writereg),
    .i_memwb_regwrite(hz.memwb_regwrite), .i_memwb_writereg(hz.memwb_writereg), .o_fwd(w_fwd_b)
  );

  assign w_taken    = hz.exmem_branch & hz.exmem_zero;
  assign w_load_use = hz.idex_memread && (hz.idex_rt != REG_ZERO) &&
                      ((hz.idex_rt == hz.ifid_rs) || (hz.idex_rt == hz.ifid_rt));

  always_comb begin
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.idex_write  = 1'b1;
    hz.exmem_write = 1'b1;
    hz.memwb_write = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.exmem_flush = 1'b0;
    hz.pc_src      = 1'b0;
    hz.kill_fx     = 1'b0;
    w_next         = ST_RUN;
    w_inc_stall    = 1'b0;
    w_inc_flush    = 1'b0;
    w_inc_freeze   = 1'b0;
    if (rst) begin
      {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write, hz.memwb_write} = 5'b0;
      {hz.ifid_flush, hz.idex_flush, hz.exmem_flush} = 3'b111;
      hz.kill_fx = 1'b1;
      w_next     = ST_FILL;
    end else if (r_state == ST_FILL) begin
      hz.kill_fx = 1'b1;
      w_next     = (r_fill == FW'(FILL_CYCLES - 1)) ? ST_RUN : ST_FILL;
    end else if (hz.mem_wait) begin
      // A pending branch stays parked in EX/MEM until the memory answers.
      {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write, hz.memwb_write} = 5'b0;
      w_inc_freeze = 1'b1;
    end else if (w_taken) begin
      {hz.ifid_flush, hz.idex_flush, hz.exmem_flush} = 3'b111;
      hz.pc_src   = 1'b1;
      w_inc_flush = 1'b1;
      w_next      = ST_FLUSH;
    end else if (w_load_use) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.idex_flush = 1'b1;
      w_inc_stall   = 1'b1;
      w_next        = ST_STALL;
    end
  end

  assign hz.fwd_a      = rst ? FWD_REG : w_fwd_a;
  assign hz.fwd_b      = rst ? FWD_REG : w_fwd_b;
  assign hz.state      = r_state;
  assign hz.stall_cnt  = r_stall_cnt;
  assign hz.flush_cnt  = r_flush_cnt;
  assign hz.freeze_cnt = r_freeze_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_FILL;
      r_fill       <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FILL)
        r_fill <= r_fill + FW'(1);
      // Counters stick at all-ones rather than wrapping.
      if (w_inc_stall && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CW'(1);
      if (w_inc_flush && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + CW'(1);
      if (w_inc_freeze && !(&r_freeze_cnt))
        r_freeze_cnt <= r_freeze_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed vector bench for hazard_controller
module tb_hazard_controller;

  localparam int CWT = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_stall = 0, m_flush = 0, m_freeze = 0;

  always #5 clk = ~clk;

  hazard_controller_if #(.CW(CWT)) hz ();

  hazard_controller #(.FILL_CYCLES(4), .CW(CWT)) dut (.clk(clk), .rst(rst), .hz(hz));

  typedef struct {
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt;
    logic       memread, ex_rw;
    logic [4:0] ex_wr;
    logic       wb_rw;
    logic [4:0] wb_wr;
    logic       br, zr, mw;
    logic [4:0] e_wr;
    logic [2:0] e_fl;
    logic       e_pc;
    logic [1:0] e_fa, e_fb, e_ns;
    int         cls;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] a, b, c, d, input logic mr, exrw, input logic [4:0] exwr,
                              input logic wbrw, input logic [4:0] wbwr, input logic br, zr, mw,
                              input logic [4:0] ewr, input logic [2:0] efl, input logic epc,
                              input logic [1:0] efa, efb, ens, input int cls);
    vec_t v;
    v.ifid_rs = a; v.ifid_rt = b; v.idex_rs = c; v.idex_rt = d;
    v.memread = mr; v.ex_rw = exrw; v.ex_wr = exwr; v.wb_rw = wbrw; v.wb_wr = wbwr;
    v.br = br; v.zr = zr; v.mw = mw;
    v.e_wr = ewr; v.e_fl = efl; v.e_pc = epc; v.e_fa = efa; v.e_fb = efb; v.e_ns = ens; v.cls = cls;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.ifid_rs = v.ifid_rs; hz.ifid_rt = v.ifid_rt; hz.idex_rs = v.idex_rs; hz.idex_rt = v.idex_rt;
    hz.idex_memread = v.memread; hz.exmem_regwrite = v.ex_rw; hz.exmem_writereg = v.ex_wr;
    hz.memwb_regwrite = v.wb_rw; hz.memwb_writereg = v.wb_wr;
    hz.exmem_branch = v.br; hz.exmem_zero = v.zr; hz.mem_wait = v.mw;
  endtask

  function automatic int writes();
    return int'({hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write, hz.memwb_write});
  endfunction

  function automatic int flushes();
    return int'({hz.ifid_flush, hz.idex_flush, hz.exmem_flush});
  endfunction

  function automatic int sat_inc(input int c);
    return (c < SAT) ? c + 1 : c;
  endfunction

  // Called just after a rising edge; checks combinational outputs mid-cycle, then state/counters after the edge.
  task automatic run_vec(input vec_t v, input string nm);
    drive(v);
    @(negedge clk);
    chk({nm, " writes"}, writes(), int'(v.e_wr));
    chk({nm, " flushes"}, flushes(), int'(v.e_fl));
    chk({nm, " pc_src"}, int'(hz.pc_src), int'(v.e_pc));
    chk({nm, " fwd_a"}, int'(hz.fwd_a), int'(v.e_fa));
    chk({nm, " fwd_b"}, int'(hz.fwd_b), int'(v.e_fb));
    chk({nm, " kill_fx"}, int'(hz.kill_fx), 0);
    @(posedge clk); #1;
    if (v.cls == 1) m_stall  = sat_inc(m_stall);
    if (v.cls == 2) m_flush  = sat_inc(m_flush);
    if (v.cls == 3) m_freeze = sat_inc(m_freeze);
    chk({nm, " state"}, int'(hz.state), int'(v.e_ns));
    chk({nm, " stall_cnt"}, int'(hz.stall_cnt), m_stall);
    chk({nm, " flush_cnt"}, int'(hz.flush_cnt), m_flush);
    chk({nm, " freeze_cnt"}, int'(hz.freeze_cnt), m_freeze);
  endtask

  vec_t idle, lu, fz, brv, fillv;

  initial begin
    idle  = mk(0,0,0,0, 0, 0,0, 0,0, 0,0,0, 5'h1F,3'b000,0, 2'b00,2'b00,2'd1, 0);
    lu    = mk(5,0,0,5, 1, 0,0, 0,0, 0,0,0, 5'b00111,3'b010,0, 2'b00,2'b00,2'd2, 1);
    fz    = mk(0,0,0,0, 0, 0,0, 0,0, 1,1,1, 5'b00000,3'b000,0, 2'b00,2'b00,2'd1, 3);
    brv   = mk(0,0,0,0, 0, 0,0, 0,0, 1,1,0, 5'h1F,3'b111,1, 2'b00,2'b00,2'd3, 2);
    fillv = mk(5,0,3,5, 1, 1,3, 0,0, 1,1,1, 5'h1F,3'b000,0, 2'b10,2'b00,2'd0, 0);

    vecs.push_back(idle);
    vecs.push_back(lu);
    vecs.push_back(mk(5,0,0,5, 0, 0,0, 0,0, 0,0,0, 5'h1F,3'b000,0, 2'b00,2'b00,2'd1, 0));
    vecs.push_back(mk(0,0,0,0, 1, 0,0, 0,0, 0,0,0, 5'h1F,3'b000,0, 2'b00,2'b00,2'd1, 0));
    vecs.push_back(mk(1,9,0,9, 1, 0,0, 0,0, 0,0,0, 5'b00111,3'b010,0, 2'b00,2'b00,2'd2, 1));
    vecs.push_back(mk(5,0,0,5, 1, 0,0, 0,0, 1,1,0, 5'h1F,3'b111,1, 2'b00,2'b00,2'd3, 2));
    vecs.push_back(mk(0,0,0,0, 0, 0,0, 0,0, 1,0,0, 5'h1F,3'b000,0, 2'b00,2'b00,2'd1, 0));
    vecs.push_back(mk(0,0,7,3, 0, 1,7, 1,7, 0,0,0, 5'h1F,3'b000,0, 2'b10,2'b00,2'd1, 0));
    vecs.push_back(mk(0,0,7,3, 0, 0,7, 1,7, 0,0,0, 5'h1F,3'b000,0, 2'b01,2'b00,2'd1, 0));
    vecs.push_back(mk(0,0,0,3, 0, 1,0, 1,0, 0,0,0, 5'h1F,3'b000,0, 2'b00,2'b00,2'd1, 0));
    vecs.push_back(mk(0,0,4,4, 0, 1,4, 1,4, 0,0,0, 5'h1F,3'b000,0, 2'b10,2'b10,2'd1, 0));
    vecs.push_back(mk(0,0,2,4, 0, 1,6, 1,4, 0,0,0, 5'h1F,3'b000,0, 2'b00,2'b01,2'd1, 0));

    // Reset, with a forwarding match present that must stay masked.
    drive(fillv);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst writes", writes(), 0);
    chk("rst flushes", flushes(), 7);
    chk("rst pc_src", int'(hz.pc_src), 0);
    chk("rst kill_fx", int'(hz.kill_fx), 1);
    chk("rst fwd_a", int'(hz.fwd_a), 0);
    chk("rst state", int'(hz.state), 0);
    chk("rst stall_cnt", int'(hz.stall_cnt), 0);
    chk("rst freeze_cnt", int'(hz.freeze_cnt), 0);
    rst = 1'b0;

    // Fill: hazards, branch and mem_wait present but ignored for four cycles.
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("fill%0d kill_fx", k), int'(hz.kill_fx), 1);
      chk($sformatf("fill%0d writes", k), writes(), 31);
      chk($sformatf("fill%0d flushes", k), flushes(), 0);
      chk($sformatf("fill%0d pc_src", k), int'(hz.pc_src), 0);
      chk($sformatf("fill%0d fwd_a", k), int'(hz.fwd_a), 2);
      chk($sformatf("fill%0d state", k), int'(hz.state), 0);
    end
    @(posedge clk); #1;
    chk("fill done state", int'(hz.state), 1);
    chk("fill done kill_fx", int'(hz.kill_fx), 0);
    chk("fill stall_cnt", int'(hz.stall_cnt), 0);
    chk("fill flush_cnt", int'(hz.flush_cnt), 0);
    chk("fill freeze_cnt", int'(hz.freeze_cnt), 0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Taken branch held off by two wait cycles, then taken.
    run_vec(fz, "freeze1");
    run_vec(fz, "freeze2");
    chk("freeze total", int'(hz.freeze_cnt), 2);
    run_vec(brv, "branch after wait");
    run_vec(idle, "after flush");

    // Saturation of the 4-bit stall counter.
    for (int n = 0; n < 20; n++) run_vec(lu, $sformatf("sat%0d", n));
    chk("stall saturated", int'(hz.stall_cnt), SAT);

    // Asynchronous reset in the middle of a STALL cycle.
    run_vec(lu, "pre-abort");
    #2 rst = 1'b1;
    #1;
    chk("abort state", int'(hz.state), 0);
    chk("abort stall_cnt", int'(hz.stall_cnt), 0);
    chk("abort writes", writes(), 0);
    chk("abort flushes", flushes(), 7);
    chk("abort kill_fx", int'(hz.kill_fx), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
